// File: rtl/div_sched.sv
// Two-requester front end sharing one iterative restoring divider.
// Round-robin arbitration, one operation in flight, one quotient bit per cycle.
module div_sched #(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [DATAWIDTH-1:0] a0,
   input  logic [DATAWIDTH-1:0] b0,
   input  logic [DATAWIDTH-1:0] a1,
   input  logic [DATAWIDTH-1:0] b1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 done0,
   output logic                 done1,
   output logic [DATAWIDTH-1:0] quot,
   output logic [DATAWIDTH-1:0] rem,
   output logic                 dbz,
   output logic                 busy
);

   localparam int unsigned CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DATAWIDTH-1:0] dvd_q, dvd_d;
   logic [DATAWIDTH-1:0] dvs_q, dvs_d;
   logic [DATAWIDTH:0]   prem_q, prem_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 owner_q, owner_d;
   logic                 last_q, last_d;
   logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                 done0_q, done0_d, done1_q, done1_d;
   logic [DATAWIDTH-1:0] quot_q, quot_d;
   logic [DATAWIDTH-1:0] rem_q, rem_d;
   logic                 dbz_q, dbz_d;

   logic [DATAWIDTH:0]   prem_sh;
   logic [DATAWIDTH:0]   prem_nx;
   logic                 fits;
   logic                 sel;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      sel     = 1'b0;

      // The dividend register doubles as the quotient shift register.
      prem_sh = {prem_q[DATAWIDTH-1:0], dvd_q[DATAWIDTH-1]};
      fits    = (prem_sh >= {1'b0, dvs_q});
      prem_nx = fits ? (prem_sh - {1'b0, dvs_q}) : prem_sh;

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               sel     = (req0 && req1) ? ~last_q : req1;
               owner_d = sel;
               last_d  = sel;
               gnt0_d  = ~sel;
               gnt1_d  = sel;
               dvd_d   = sel ? a1 : a0;
               dvs_d   = sel ? b1 : b0;
               prem_d  = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A zero divisor spends its single BUSY cycle here, then reports.
            if (dvs_q == '0) begin
               quot_d  = '1;
               rem_d   = dvd_q;
               dbz_d   = 1'b1;
               done0_d = ~owner_q;
               done1_d = owner_q;
               state_d = DONE;
            end else begin
               dvd_d  = {dvd_q[DATAWIDTH-2:0], fits};
               prem_d = prem_nx;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(DATAWIDTH - 1)) begin
                  quot_d  = {dvd_q[DATAWIDTH-2:0], fits};
                  rem_d   = prem_nx[DATAWIDTH-1:0];
                  dbz_d   = 1'b0;
                  done0_d = ~owner_q;
                  done1_d = owner_q;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign quot  = quot_q;
   assign rem   = rem_q;
   assign dbz   = dbz_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, giving the operand, quotient and remainder width in bits; legal range 2..32.
REQ-002 SHALL have port Clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL have port Rst, input, 1 bit, the reset: asynchronous and active-low (one clock; reset is asynchronous and active-low).
REQ-004 SHALL have ports req0 and req1, input, 1 bit each, a division request from requester 0 or 1, held high until granted.
REQ-005 SHALL have ports a0 and b0, input, DATAWIDTH each, the unsigned dividend and divisor of requester 0, stable while req0 is high.
REQ-006 SHALL have ports a1 and b1, input, DATAWIDTH each, the same for requester 1.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 bit each, a registered one-cycle pulse meaning the operands were accepted.
REQ-008 SHALL have ports done0 and done1, output, 1 bit each, a registered one-cycle pulse meaning the result for that requester is valid.
REQ-009 SHALL have port quot, output, DATAWIDTH, the unsigned quotient.
REQ-010 SHALL have port rem, output, DATAWIDTH, the unsigned remainder.
REQ-011 SHALL have port dbz, output, 1 bit, the divide-by-zero flag for the current result.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE, sharing one iterative restoring divider that produces one quotient bit per cycle.
REQ-014 In IDLE with any request high, the clock edge k SHALL accept one request: latch its a and b, record the owner, and assert that owner's gnt for the cycle [k, k+1).
REQ-015 In IDLE with both requests high, arbitration SHALL be round-robin and grant the requester not served last; with a single request, that requester SHALL be granted.
REQ-016 The last-served pointer SHALL update on every acceptance.
REQ-017 From acceptance with b != 0, the state SHALL go to BUSY and perform exactly DATAWIDTH iterations, at edges k+1 through k+DATAWIDTH, MSB first.
REQ-018 Each iteration SHALL shift the partial remainder left by one bit with the next dividend bit appended, and subtract b when the result is >= b.
REQ-019 The partial remainder SHALL be DATAWIDTH+1 bits wide, so the intermediate result never overflows.
REQ-020 At edge k+DATAWIDTH the state SHALL go to DONE; quot, rem and dbz=0 SHALL update, and the owner's done SHALL be high for the cycle [k+DATAWIDTH, k+DATAWIDTH+1).
REQ-021 With b == 0 at acceptance, the state SHALL go directly to DONE at edge k+1 with quot = all ones, rem = a, dbz = 1, and the owner's done high for one cycle.
REQ-022 DONE SHALL return to IDLE at the next edge unconditionally; the earliest next acceptance is that following IDLE edge, so throughput is one operation per DATAWIDTH+2 cycles.
REQ-023 Requests SHALL be ignored outside IDLE; a requester that keeps req high after its gnt SHALL be treated as issuing a new operation.
REQ-024 quot, rem and dbz SHALL hold their values from the last DONE until the next DONE.
REQ-025 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.
REQ-026 At most one operation SHALL be in flight at any time.
REQ-027 Operand changes on the requester inputs after gnt SHALL NOT affect the operation in flight.

Reset
REQ-028 Rst low SHALL immediately force state IDLE, and quot, rem, dbz, gnt0, gnt1, done0, done1 and busy all to 0.
REQ-029 Rst low SHALL clear the iteration counter and operand registers, and set the last-served pointer to 1 so that requester 0 wins the first tie.
REQ-030 Reset asserted mid-operation SHALL abort it with no done pulse; after Rst returns high, the first edge in IDLE SHALL accept normally.

Verification (DATAWIDTH=8)
REQ-031 req0=1, a0=100, b0=7, req1=0 -> gnt0 high the cycle after acceptance edge k; done0 high during [k+8, k+9) with quot=14, rem=2, dbz=0.
REQ-032 req0=req1=1 from reset, held for three operations -> grant order 0, 1, 0; each done goes only to the owner.
REQ-033 req1=1, a1=55, b1=0 -> done1 high during [k+1, k+2) with quot=255, rem=55, dbz=1.
REQ-034 a0=255, b0=1, then a0=3, b0=200 -> quot=255, rem=0; then quot=0, rem=3.
REQ-035 Rst pulsed low at iteration 4 of an operation -> all outputs 0 immediately, no done pulse; a new request after release completes in 8 iterations.
REQ-036 Change a0/b0 the cycle after gnt0 -> the result matches the operands latched at acceptance.
